// File: rtl/data_mem_responder_pkg.sv
// Shared types for the core's data-memory interface.
// Holds the request/response bundles, default responder geometry and a small
// address-validity helper used by the responder.
package data_mem_responder_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned data_mem_latency_gp    = 2;
    localparam int unsigned data_mem_fifo_depth_gp = 4;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [3:0]  byte_en;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } mem_resp_s;

    // A byte address is bad when misaligned or beyond the word-indexed storage.
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned addr_width);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_width + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_resp_fifo.sv
// Response FIFO for the data-memory responder.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   push, data_in    enqueue one entry
//   pop              dequeue the head (ignored when empty)
//   data_out         head entry, read straight out of the storage flops
//   full, empty      occupancy flags
module data_mem_resp_fifo #(
    parameter int unsigned depth_p = 4,
    parameter int unsigned width_p = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] data_in,
    input  logic               pop,
    output logic [width_p-1:0] data_out,
    output logic               full,
    output logic               empty
);

    localparam int unsigned ptr_width_lp = $clog2(depth_p);
    typedef logic [ptr_width_lp-1:0] ptr_t;
    typedef logic [ptr_width_lp:0]   cnt_t;
    localparam cnt_t depth_lp = cnt_t'(depth_p);

    logic [width_p-1:0] entries [depth_p];
    ptr_t wr_ptr_q, rd_ptr_q;
    cnt_t count_q, count_d;
    logic do_pop;

    assign full     = (count_q == depth_lp);
    assign empty    = (count_q == '0);
    assign do_pop   = pop & ~empty;
    assign data_out = entries[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !do_pop) begin
            count_d = count_q + cnt_t'(1);
        end else if (!push && do_pop) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    // Pointers wrap on their own because depth_p is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
        end
    end

    // When full, push only coincides with pop, so overwriting the head slot is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr_q] <= data_in;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && full && !do_pop));

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: memory-side end of the core's load/store interface.
// Writes update local storage with byte enables; reads are returned in order
// after latency_p cycles through a response FIFO that absorbs core stalls.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid_i/req_wen_i      request present / write (1) or read (0)
//   req_byte_en_i              write byte enables
//   req_addr_i, req_wdata_i    byte address and write data
//   req_yumi_o                 request accepted this cycle
//   resp_valid_o, resp_data_o  read data at FIFO head
//   resp_yumi_i                core consumes the head
//   err_o                      sticky address error flag
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = data_mem_latency_gp,
    parameter int unsigned fifo_depth_p = data_mem_fifo_depth_gp
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic [3:0]  req_byte_en_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_yumi_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    input  logic        resp_yumi_i,
    output logic        err_o
);

    localparam int unsigned cnt_width_lp = $clog2(fifo_depth_p) + 1;
    typedef logic [cnt_width_lp-1:0] cnt_t;
    localparam cnt_t depth_lp = cnt_t'(fifo_depth_p);

    mem_req_s                req;
    logic                    req_bad;
    logic [addr_width_p-1:0] word_idx;
    logic                    wr_fire, rd_fire, resp_fire;
    cnt_t                    outstanding_q, outstanding_d;
    logic                    err_q;
    logic                    fifo_full, fifo_empty;
    mem_resp_s               rd_in, push_side;
    logic [31:0]             storage [2**addr_width_p];

    assign req = '{valid:   req_valid_i,
                   wen:     req_wen_i,
                   byte_en: req_byte_en_i,
                   addr:    req_addr_i,
                   wdata:   req_wdata_i};

    assign req_bad  = addr_is_bad(req.addr, addr_width_p);
    assign word_idx = req.addr[addr_width_p+1:2];

    // Credit check looks only at the registered count; a pop this cycle frees
    // its credit next cycle.
    assign req_yumi_o = req.valid & ~reset & (req.wen | (outstanding_q < depth_lp));
    assign wr_fire    = req_yumi_o & req.wen & ~req_bad;
    assign rd_fire    = req_yumi_o & ~req.wen;

    assign resp_valid_o = ~fifo_empty & ~reset;
    assign resp_fire    = resp_valid_o & resp_yumi_i;
    assign err_o        = err_q & ~reset;

    // Storage is deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (req.byte_en[k]) begin
                    storage[word_idx][8*k +: 8] <= req.wdata[8*k +: 8];
                end
            end
        end
    end

    assign rd_in.valid = rd_fire;
    assign rd_in.data  = req_bad ? 32'h0 : storage[word_idx];

    // latency_p-1 register stages between the storage read and the FIFO push.
    if (latency_p == 1) begin : g_no_pipe
        assign push_side = rd_in;
    end else begin : g_pipe
        mem_resp_s stage_q [latency_p-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(latency_p) - 1; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= rd_in;
                for (int i = 1; i < int'(latency_p) - 1; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign push_side = stage_q[latency_p-2];
    end

    data_mem_resp_fifo #(
        .depth_p (fifo_depth_p),
        .width_p (32)
    ) u_resp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_side.valid),
        .data_in  (push_side.data),
        .pop      (resp_fire),
        .data_out (resp_data_o),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_fire && !resp_fire) begin
            outstanding_d = outstanding_q + cnt_t'(1);
        end else if (!rd_fire && resp_fire) begin
            outstanding_d = outstanding_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (req_yumi_o && req_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // A full FIFO implies every credit is held by a FIFO entry.
    credit_a: assert property (@(posedge clk) disable iff (reset)
                               fifo_full |-> (outstanding_q == depth_lp));

endmodule
